// File: rtl/rom_dram_loader_pkg.sv
// Shared types for the boot-time ROM to DRAM copier.
// FSM states, default widths and the byte-to-word address map.
package rom_dram_loader_pkg;

    localparam int ROM_AW_DEF = 19;
    localparam int RAM_AW_DEF = 21;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        WRITE,
        DONE
    } state_t;

    function automatic logic [31:0] word_addr(
        input logic [31:0] base,
        input logic [31:0] idx
    );
        return base + (idx >> 1);
    endfunction

endpackage

// File: rtl/rom_dram_loader_if.sv
// DRAM arbiter write port: request, address, data and byte enables
// from the loader, acknowledge back from the arbiter.
interface rom_dram_loader_if
    import rom_dram_loader_pkg::*;
#(
    parameter int AW = RAM_AW_DEF
) ();

    logic          req;
    logic [AW-1:0] addr;
    logic [15:0]   wrdata;
    logic [1:0]    bsel;
    logic          ack;

    modport master (
        output req, addr, wrdata, bsel,
        input  ack
    );

    modport slave (
        input  req, addr, wrdata, bsel,
        output ack
    );

endinterface

// File: rtl/rom_dram_loader_fetch.sv
// ROM byte fetch: presents the byte address and strobes byte_valid
// once ROM_LAT cycles have elapsed inside a fetch state.
module rom_dram_loader_fetch
    import rom_dram_loader_pkg::*;
#(
    parameter int ROM_AW  = ROM_AW_DEF,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ROM_AW-1:0] idx,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              byte_valid,
    output logic [7:0]        byte_data
);

    logic [1:0] cnt;

    localparam logic [1:0] LAST = 2'(ROM_LAT - 1);

    // idx is a register, so the ROM address changes only on a clock edge
    assign rom_addr   = idx;
    assign byte_data  = rom_data;
    assign byte_valid = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || byte_valid) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rom_dram_loader.sv
// Boot copier: packs ROM byte pairs into 16-bit DRAM words and
// holds the CPU in reset until the whole image is written.
module rom_dram_loader
    import rom_dram_loader_pkg::*;
#(
    parameter int ROM_AW    = ROM_AW_DEF,
    parameter int LEN_BYTES = 507904,
    parameter int RAM_AW    = RAM_AW_DEF,
    parameter int RAM_BASE  = 0,
    parameter int ROM_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    rom_dram_loader_if.master dram,
    output logic              busy,
    output logic              done,
    output logic              cpu_rst_n
);

    localparam logic [ROM_AW:0] LEN = LEN_BYTES[ROM_AW:0];

    state_t            state;
    logic [ROM_AW:0]   idx;
    logic              fetch_en;
    logic              byte_valid;
    logic              last;
    logic [7:0]        byte_data;
    logic [RAM_AW-1:0] waddr;

    assign fetch_en = (state == FETCH_LO) || (state == FETCH_HI);
    assign last     = (idx + 1'b1) == LEN;
    assign waddr    = RAM_AW'(word_addr(RAM_BASE, 32'(idx)));

    rom_dram_loader_fetch #(
        .ROM_AW  (ROM_AW),
        .ROM_LAT (ROM_LAT)
    ) u_fetch (
        .clk        (clk),
        .rst        (rst),
        .en         (fetch_en),
        .idx        (idx[ROM_AW-1:0]),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            dram.req    <= 1'b0;
            dram.addr   <= RAM_BASE[RAM_AW-1:0];
            dram.wrdata <= '0;
            dram.bsel   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cpu_rst_n   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx <= '0;
                        if (LEN == '0) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state     <= FETCH_LO;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            cpu_rst_n <= 1'b0;
                        end
                    end
                end
                FETCH_LO: begin
                    if (byte_valid) begin
                        dram.wrdata[7:0] <= byte_data;
                        if (last) begin
                            dram.bsel <= 2'b01;
                            dram.req  <= 1'b1;
                            dram.addr <= waddr;
                            state     <= WRITE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH_HI;
                        end
                    end
                end
                FETCH_HI: begin
                    if (byte_valid) begin
                        dram.wrdata[15:8] <= byte_data;
                        dram.bsel         <= 2'b11;
                        dram.req          <= 1'b1;
                        dram.addr         <= waddr;
                        state             <= WRITE;
                    end
                end
                WRITE: begin
                    // req is high for the whole state, so ack is always qualified
                    if (dram.ack) begin
                        dram.req <= 1'b0;
                        if (last) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH_LO;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_dram_loader.sv
// Directed bench: five loader instances with different lengths,
// latencies and bases, each with a ROM model and a write monitor.
module tb_rom_dram_loader;

    localparam logic [4:0][31:0] LENS  = {32'd4096, 32'd0, 32'd8, 32'd3, 32'd4};
    localparam logic [4:0][31:0] LATS  = {32'd1, 32'd1, 32'd2, 32'd3, 32'd1};
    localparam logic [4:0][31:0] BASES = {32'd2000, 32'h100, 32'h100, 32'h100, 32'h100};
    localparam logic [4:0][31:0] ROMAW = {32'd12, 32'd19, 32'd19, 32'd19, 32'd19};
    localparam logic [4:0][31:0] RAMAW = {32'd11, 32'd21, 32'd21, 32'd21, 32'd21};

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] start_v;
    logic [4:0] ack_v;
    logic [4:0] busy_v;
    logic [4:0] done_v;
    logic [4:0] crn_v;
    logic [4:0] req_v;
    logic [7:0] rom [4096];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : u
        localparam int LEN  = int'(LENS[g]);
        localparam int LAT  = int'(LATS[g]);
        localparam int BASE = int'(BASES[g]);
        localparam int RA   = int'(ROMAW[g]);
        localparam int RW   = int'(RAMAW[g]);

        rom_dram_loader_if #(.AW(RW)) dram ();

        logic [RA-1:0] rom_addr, ap1, ap2, ap3, asel;
        logic [7:0]    rom_data;

        assign dram.ack = ack_v[g];
        assign req_v[g] = dram.req;

        rom_dram_loader #(
            .ROM_AW    (RA),
            .LEN_BYTES (LEN),
            .RAM_AW    (RW),
            .RAM_BASE  (BASE),
            .ROM_LAT   (LAT)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_v[g]),
            .rom_addr  (rom_addr),
            .rom_data  (rom_data),
            .dram      (dram),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .cpu_rst_n (crn_v[g])
        );

        // ROM model: data reflects the address LAT-1 edges ago
        always_ff @(posedge clk) begin
            ap1 <= rom_addr;
            ap2 <= ap1;
            ap3 <= ap2;
        end

        always_comb begin
            case (LAT)
                2:       asel = ap1;
                3:       asel = ap2;
                4:       asel = ap3;
                default: asel = rom_addr;
            endcase
        end

        assign rom_data = rom[12'(asel)];

        int            wcnt, nreq, merr;
        logic          bseen, req_q;
        logic [RW-1:0] first_addr, last_addr;
        logic [15:0]   last_data, ed, mask;
        logic [1:0]    last_bsel, eb;
        logic [31:0]   ea;

        always_comb begin
            ea   = 32'(BASE) + 32'(wcnt);
            eb   = (2 * wcnt + 1 < LEN) ? 2'b11 : 2'b01;
            ed   = {rom[(2 * wcnt + 1) % 4096], rom[(2 * wcnt) % 4096]};
            mask = eb[1] ? 16'hFFFF : 16'h00FF;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wcnt  <= 0;
                nreq  <= 0;
                merr  <= 0;
                bseen <= 1'b0;
                req_q <= 1'b0;
            end else begin
                req_q <= dram.req;
                if (busy_v[g]) bseen <= 1'b1;
                if (start_v[g] && !busy_v[g]) begin
                    wcnt <= 0;
                    nreq <= 0;
                end else begin
                    if (dram.req && !req_q) nreq <= nreq + 1;
                    if (dram.req && dram.ack) begin
                        wcnt      <= wcnt + 1;
                        last_addr <= dram.addr;
                        last_data <= dram.wrdata;
                        last_bsel <= dram.bsel;
                        if (wcnt == 0) first_addr <= dram.addr;
                        if (dram.addr != ea[RW-1:0] || dram.bsel != eb ||
                            ((dram.wrdata ^ ed) & mask) != 16'h0)
                            merr <= merr + 1;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input int g);
        @(negedge clk);
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget, output int n);
        n = 0;
        while (!done_v[g] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("done%0d", g), 32'(done_v[g]), 32'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) begin
            if (i < 8)        rom[i] = 8'(17 * (i + 1));
            else if (i < 186) rom[i] = 8'(i * 37 + 5);
            else              rom[i] = 8'hFF;
        end
        rst     = 1'b1;
        start_v = '0;
        ack_v   = '1;
        repeat (2) @(negedge clk);
        check("rst_rom_addr", 32'(u[0].rom_addr), 0);
        check("rst_req", 32'(req_v[0]), 0);
        check("rst_addr", 32'(u[0].dram.addr), 'h100);
        check("rst_wrdata", 32'(u[0].dram.wrdata), 0);
        check("rst_bsel", 32'(u[0].dram.bsel), 0);
        check("rst_busy", 32'(busy_v[0]), 0);
        check("rst_done", 32'(done_v[0]), 0);
        check("rst_crn", 32'(crn_v[0]), 0);
        rst = 1'b0;

        pulse(0);
        check("basic_busy", 32'(busy_v[0]), 1);
        check("basic_crn_lo", 32'(crn_v[0]), 0);
        wait_done(0, 50, n);
        check("basic_cycles", n, 6);
        check("basic_wcnt", u[0].wcnt, 2);
        check("basic_last_addr", 32'(u[0].last_addr), 'h101);
        check("basic_last_data", 32'(u[0].last_data), 'h4433);
        check("basic_last_bsel", 32'(u[0].last_bsel), 3);
        check("basic_first_addr", 32'(u[0].first_addr), 'h100);
        check("basic_merr", u[0].merr, 0);
        check("basic_crn_hi", 32'(crn_v[0]), 1);
        check("basic_busy_lo", 32'(busy_v[0]), 0);

        ack_v[0] = 1'b0;
        pulse(0);
        check("restart_done", 32'(done_v[0]), 0);
        check("restart_crn", 32'(crn_v[0]), 0);
        n = 0;
        while (!req_v[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 7; i++) begin
            check("stall_req", 32'(req_v[0]), 1);
            check("stall_addr", 32'(u[0].dram.addr), 'h100);
            check("stall_data", 32'(u[0].dram.wrdata), 'h2211);
            if (i == 3) start_v[0] = 1'b1;
            if (i == 4) start_v[0] = 1'b0;
            @(negedge clk);
        end
        ack_v[0] = 1'b1;
        wait_done(0, 50, n);
        check("stall_wcnt", u[0].wcnt, 2);
        check("stall_nreq", u[0].nreq, 2);
        check("stall_merr", u[0].merr, 0);

        pulse(1);
        wait_done(1, 80, n);
        check("odd_cycles", n, 11);
        check("odd_wcnt", u[1].wcnt, 2);
        check("odd_nreq", u[1].nreq, 2);
        check("odd_last_addr", 32'(u[1].last_addr), 'h101);
        check("odd_last_bsel", 32'(u[1].last_bsel), 1);
        check("odd_last_lo", 32'(u[1].last_data[7:0]), 'h33);
        check("odd_merr", u[1].merr, 0);

        pulse(2);
        n = 0;
        while (!(req_v[2] && u[2].wcnt == 1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_pre_req", 32'(req_v[2]), 1);
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(req_v[2]), 0);
        check("midrst_busy", 32'(busy_v[2]), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_idle_busy", 32'(busy_v[2]), 0);
        check("midrst_idle_req", 32'(req_v[2]), 0);
        pulse(2);
        wait_done(2, 100, n);
        check("midrst_cycles", n, 20);
        check("midrst_first_addr", 32'(u[2].first_addr), 'h100);
        check("midrst_wcnt", u[2].wcnt, 4);
        check("midrst_merr", u[2].merr, 0);

        pulse(3);
        check("zero_done", 32'(done_v[3]), 1);
        check("zero_crn", 32'(crn_v[3]), 1);
        repeat (3) @(negedge clk);
        check("zero_busy_seen", 32'(u[3].bseen), 0);
        check("zero_nreq", u[3].nreq, 0);

        pulse(4);
        wait_done(4, 20000, n);
        check("full_cycles", n, 6144);
        check("full_wcnt", u[4].wcnt, 2048);
        check("full_first_addr", 32'(u[4].first_addr), 2000);
        check("full_last_addr", 32'(u[4].last_addr), 1999);
        check("full_last_data", 32'(u[4].last_data), 'hFFFF);
        check("full_rom_addr", 32'(u[4].rom_addr), 4095);
        check("full_merr", u[4].merr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
